sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_if.sv | 36 +++
 rtl/sdram_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
// AXI4-Lite bus between the arbiter and the memory-side slave.
// 32-bit address and data, 4-bit write strobes, 2-bit responses.
//   master modport : arbiter side (drives addresses, data, valids and
//                    response readies)
//   slave  modport : memory side (drives address/data readies and the
//                    read/write responses)
interface sdram_arbiter_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, awaddr, awvalid, wdata, wstrb, wvalid, bready, rready,
    input  arready, awready, wready, bresp, bvalid, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, awaddr, awvalid, wdata, wstrb, wvalid, bready, rready,
    output arready, awready, wready, bresp, bvalid, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Two-port request arbiter in front of a single AXI4-Lite master port.
// Only one transaction is ever outstanding; the granted port's request
// fields are captured on the grant edge and replayed onto the bus.
//   FIXED_PRIO    : 0 = round-robin between ports, 1 = port 0 always wins
//   clk, rstn     : clock (rising edge), asynchronous active-low reset
//   reqN_valid/we/addr/wdata/wstrb : request from port N (N = 0, 1)
//   reqN_ack      : one-cycle pulse, request captured
//   reqN_done     : one-cycle pulse, access complete
//   reqN_rdata/err: read data / error flag, valid with reqN_done
//   m_axi         : AXI4-Lite master port
module sdram_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req0_valid,
  input  logic                   req0_we,
  input  logic [31:0]            req0_addr,
  input  logic [31:0]            req0_wdata,
  input  logic [3:0]             req0_wstrb,
  output logic                   req0_ack,
  output logic                   req0_done,
  output logic [31:0]            req0_rdata,
  output logic                   req0_err,
  input  logic                   req1_valid,
  input  logic                   req1_we,
  input  logic [31:0]            req1_addr,
  input  logic [31:0]            req1_wdata,
  input  logic [3:0]             req1_wstrb,
  output logic                   req1_ack,
  output logic                   req1_done,
  output logic [31:0]            req1_rdata,
  output logic                   req1_err,
  sdram_arbiter_if.master        m_axi
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP
  } state_t;

  state_t      state, state_next;
  logic        last_grant;
  logic        cur_port;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        arvalid_q, awvalid_q, wvalid_q, bready_q, rready_q;

  logic        grant_valid;
  logic        grant_port;
  logic        grant_we;
  logic        aw_done, w_done;

  // One captured address serves both read and write channels.
  assign m_axi.araddr  = addr_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.rready  = rready_q;

  // A write channel counts as finished once its valid has dropped or is
  // being accepted this cycle, so aw and w may complete in any order.
  assign aw_done = !awvalid_q || m_axi.awready;
  assign w_done  = !wvalid_q  || m_axi.wready;

  // On a tie, round-robin picks the port that did not win last time.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_port  = 1'b0;
    if (req0_valid && req1_valid)
      grant_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else if (req1_valid)
      grant_port = 1'b1;
    grant_we = grant_port ? req1_we : req0_we;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (grant_valid) state_next = grant_we ? WR_ADDR_DATA : RD_ADDR;
      RD_ADDR:      if (arvalid_q && m_axi.arready) state_next = RD_DATA;
      RD_DATA:      if (rready_q && m_axi.rvalid) state_next = IDLE;
      WR_ADDR_DATA: if (aw_done && w_done) state_next = WR_RESP;
      WR_RESP:      if (bready_q && m_axi.bvalid) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // Bus handshakes, request capture and per-port responses. Only the
  // granted port's rdata/err are ever written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      rready_q   <= 1'b0;
      req0_ack   <= 1'b0;
      req0_done  <= 1'b0;
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_ack   <= 1'b0;
      req1_done  <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;
    end else begin
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_port;
            cur_port   <= grant_port;
            addr_q     <= grant_port ? req1_addr  : req0_addr;
            wdata_q    <= grant_port ? req1_wdata : req0_wdata;
            wstrb_q    <= grant_port ? req1_wstrb : req0_wstrb;
            req0_ack   <= ~grant_port;
            req1_ack   <= grant_port;
            if (grant_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              arvalid_q <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (arvalid_q && m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (rready_q && m_axi.rvalid) begin
            rready_q <= 1'b0;
            if (cur_port) begin
              req1_rdata <= m_axi.rdata;
              req1_err   <= (m_axi.rresp != 2'b00);
              req1_done  <= 1'b1;
            end else begin
              req0_rdata <= m_axi.rdata;
              req0_err   <= (m_axi.rresp != 2'b00);
              req0_done  <= 1'b1;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done)          bready_q  <= 1'b1;
        end
        WR_RESP: begin
          if (bready_q && m_axi.bvalid) begin
            bready_q <= 1'b0;
            if (cur_port) begin
              req1_err  <= (m_axi.bresp != 2'b00);
              req1_done <= 1'b1;
            end else begin
              req0_err  <= (m_axi.bresp != 2'b00);
              req0_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
